// File: rtl/clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_seq
// Purpose  : Ordered reset release sequencer. It sits downstream of the reset
//            synchronizer and releases NUM_DOMAINS active-low domain resets one
//            at a time, in index order, spaced RELEASE_DLY cycles apart. A
//            level soft-reset request received in RUN re-asserts every domain,
//            holds them for SOFT_RST_CYCLES, pulses an acknowledge, and then
//            re-runs the release sequence.
// Ports    : clk          - sole clock, posedge
//            rst          - synchronous active-high reset
//            soft_rst_req - level soft-reset request, honoured only in RUN
//            soft_rst_ack - one-cycle pulse when the soft-reset hold ends
//            domain_rstN  - active-low domain resets, bit 0 released first
//            seq_done     - high while every domain is released (RUN)
//            seq_state    - 0 = SEQ, 1 = RUN, 2 = SOFT
// Revision : 1.0 - initial release
// ============================================================================
module clk_rst_seq #(
    parameter int NUM_DOMAINS     = 4,
    parameter int RELEASE_DLY     = 16,
    parameter int SOFT_RST_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst_req,
    output logic                   soft_rst_ack,
    output logic [NUM_DOMAINS-1:0] domain_rstN,
    output logic                   seq_done,
    output logic [1:0]             seq_state
);

    // One counter serves both the release gap and the soft-reset hold, so it
    // is sized for the larger of the two.
    localparam int c_CNT_MAX = (RELEASE_DLY > SOFT_RST_CYCLES) ? RELEASE_DLY : SOFT_RST_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [c_CNT_W-1:0] c_REL_LAST  = c_CNT_W'(RELEASE_DLY - 1);
    localparam logic [c_CNT_W-1:0] c_SOFT_LAST = c_CNT_W'(SOFT_RST_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(NUM_DOMAINS - 1);

    localparam logic [1:0] ST_SEQ  = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SOFT = 2'd2;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [NUM_DOMAINS-1:0] r_domain_rstN;
    logic                   r_seq_done;
    logic                   r_soft_rst_ack;
    logic [NUM_DOMAINS-1:0] w_rel_mask;

    // One-hot mask of the domain due for release. OR-ing it into the current
    // vector keeps already-released bits high, so release is monotonic.
    always_comb begin
        w_rel_mask = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_rel_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_SEQ;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_domain_rstN  <= '0;
            r_seq_done     <= 1'b0;
            r_soft_rst_ack <= 1'b0;
        end else begin
            r_soft_rst_ack <= 1'b0;
            case (r_state)
                ST_SEQ: begin
                    if (r_cnt == c_REL_LAST) begin
                        r_cnt         <= '0;
                        r_domain_rstN <= r_domain_rstN | w_rel_mask;
                        // idx parks on the last domain rather than wrapping;
                        // leaving SOFT is what rewinds it.
                        if (r_idx == c_IDX_LAST) begin
                            r_state    <= ST_RUN;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (soft_rst_req) begin
                        r_state       <= ST_SOFT;
                        r_cnt         <= '0;
                        r_domain_rstN <= '0;
                        r_seq_done    <= 1'b0;
                    end
                end
                ST_SOFT: begin
                    if (r_cnt == c_SOFT_LAST) begin
                        r_state        <= ST_SEQ;
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_soft_rst_ack <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // Encoding 3 is unreachable; recover to a clean restart.
                    r_state       <= ST_SEQ;
                    r_cnt         <= '0;
                    r_idx         <= '0;
                    r_domain_rstN <= '0;
                    r_seq_done    <= 1'b0;
                end
            endcase
        end
    end

    assign soft_rst_ack = r_soft_rst_ack;
    assign domain_rstN  = r_domain_rstN;
    assign seq_done     = r_seq_done;
    assign seq_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_rst_seq
// Purpose  : Directed self-checking bench for clk_rst_seq. One instance uses
//            the default parameters; a second uses 1/1/1 for the minimal
//            configuration. Expected values are hand-computed edge counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic [3:0] domain_rstN;
    logic       seq_done;
    logic [1:0] seq_state;

    logic       rst1;
    logic       soft_rst_req1;
    logic       soft_rst_ack1;
    logic [0:0] domain_rstN1;
    logic       seq_done1;
    logic [1:0] seq_state1;

    int n_cmp   = 0;
    int n_bad   = 0;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    clk_rst_seq #(
        .NUM_DOMAINS    (4),
        .RELEASE_DLY    (16),
        .SOFT_RST_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst_req(soft_rst_req),
        .soft_rst_ack(soft_rst_ack),
        .domain_rstN (domain_rstN),
        .seq_done    (seq_done),
        .seq_state   (seq_state)
    );

    clk_rst_seq #(
        .NUM_DOMAINS    (1),
        .RELEASE_DLY    (1),
        .SOFT_RST_CYCLES(1)
    ) dut1 (
        .clk         (clk),
        .rst         (rst1),
        .soft_rst_req(soft_rst_req1),
        .soft_rst_ack(soft_rst_ack1),
        .domain_rstN (domain_rstN1),
        .seq_done    (seq_done1),
        .seq_state   (seq_state1)
    );

    // Counts ack pulses of the default instance so duplicate or missing acks show up.
    always @(negedge clk) begin
        if (soft_rst_ack === 1'b1) ack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        soft_rst_req  = 1'b0;
        rst1          = 1'b1;
        soft_rst_req1 = 1'b0;

        // 1: reset values, then ordered release at edges 16/32/48/64
        ticks(5);
        chk("rst_dom",   domain_rstN, 4'h0);
        chk("rst_done",  seq_done, 1'b0);
        chk("rst_state", seq_state, 2'd0);
        chk("rst_ack",   soft_rst_ack, 1'b0);
        rst = 1'b0;
        ticks(15); chk("s1_e15_dom", domain_rstN, 4'h0);
        tick();    chk("s1_e16_dom", domain_rstN, 4'h1);
        ticks(16); chk("s1_e32_dom", domain_rstN, 4'h3);
        ticks(16); chk("s1_e48_dom", domain_rstN, 4'h7);
        ticks(15); chk("s1_e63_dom", domain_rstN, 4'h7);
                   chk("s1_e63_done", seq_done, 1'b0);
        tick();    chk("s1_e64_dom", domain_rstN, 4'hF);
                   chk("s1_e64_done", seq_done, 1'b1);
                   chk("s1_e64_state", seq_state, 2'd1);

        // 2: soft reset from RUN, req dropped on ack
        soft_rst_req = 1'b1;
        tick();    chk("s2_S_dom", domain_rstN, 4'h0);
                   chk("s2_S_state", seq_state, 2'd2);
                   chk("s2_S_done", seq_done, 1'b0);
        ticks(7);  chk("s2_S7_ack", soft_rst_ack, 1'b0);
                   chk("s2_S7_state", seq_state, 2'd2);
        tick();    chk("s2_S8_ack", soft_rst_ack, 1'b1);
                   chk("s2_S8_state", seq_state, 2'd0);
        soft_rst_req = 1'b0;
        tick();    chk("s2_S9_ack", soft_rst_ack, 1'b0);
        ticks(14); chk("s2_S23_dom", domain_rstN, 4'h0);
        tick();    chk("s2_S24_dom", domain_rstN, 4'h1);
        ticks(47); chk("s2_S71_done", seq_done, 1'b0);
        tick();    chk("s2_S72_done", seq_done, 1'b1);
                   chk("s2_S72_dom", domain_rstN, 4'hF);
                   chk("s2_ackcnt", ack_cnt, 1);

        // 3: rst mid-sequence at edge 40 abandons it without an ack
        rst = 1'b1; tick(); rst = 1'b0;
        ticks(39); chk("s3_e39_dom", domain_rstN, 4'h3);
        rst = 1'b1;
        tick();    chk("s3_e40_dom", domain_rstN, 4'h0);
                   chk("s3_e40_state", seq_state, 2'd0);
        rst = 1'b0;
        ticks(15); chk("s3_r15_dom", domain_rstN, 4'h0);
        tick();    chk("s3_r16_dom", domain_rstN, 4'h1);
                   chk("s3_ackcnt", ack_cnt, 1);

        // 4: req held from mid-SEQ; acts only at the edge after RUN entry
        soft_rst_req = 1'b1;
        ticks(16); chk("s4_e32_dom", domain_rstN, 4'h3);
                   chk("s4_e32_state", seq_state, 2'd0);
        ticks(32); chk("s4_e64_dom", domain_rstN, 4'hF);
                   chk("s4_e64_state", seq_state, 2'd1);
        tick();    chk("s4_e65_state", seq_state, 2'd2);
                   chk("s4_e65_dom", domain_rstN, 4'h0);
        ticks(7);  chk("s4_e72_ack", soft_rst_ack, 1'b0);
        tick();    chk("s4_e73_ack", soft_rst_ack, 1'b1);
        soft_rst_req = 1'b0;
        ticks(64); chk("s4_e137_dom", domain_rstN, 4'hF);
                   chk("s4_e137_state", seq_state, 2'd1);
                   chk("s4_ackcnt", ack_cnt, 2);
        tick();    chk("s4_e138_state", seq_state, 2'd1);

        // 5: rst and req together in RUN -> reset wins, no ack
        rst = 1'b1; soft_rst_req = 1'b1;
        tick();    chk("s5_state", seq_state, 2'd0);
                   chk("s5_dom", domain_rstN, 4'h0);
                   chk("s5_ack", soft_rst_ack, 1'b0);
                   chk("s5_done", seq_done, 1'b0);
        rst = 1'b0; soft_rst_req = 1'b0;
        ticks(16); chk("s5_e16_dom", domain_rstN, 4'h1);
        ticks(48); chk("s5_e64_dom", domain_rstN, 4'hF);
                   chk("s5_e64_done", seq_done, 1'b1);
                   chk("s5_ackcnt", ack_cnt, 2);

        // 6: minimal configuration 1/1/1
        chk("s6_rst_dom", domain_rstN1, 1'b0);
        chk("s6_rst_state", seq_state1, 2'd0);
        rst1 = 1'b0;
        tick();    chk("s6_e1_dom", domain_rstN1, 1'b1);
                   chk("s6_e1_done", seq_done1, 1'b1);
                   chk("s6_e1_state", seq_state1, 2'd1);
        soft_rst_req1 = 1'b1;
        tick();    chk("s6_S_state", seq_state1, 2'd2);
                   chk("s6_S_dom", domain_rstN1, 1'b0);
        tick();    chk("s6_S1_ack", soft_rst_ack1, 1'b1);
                   chk("s6_S1_dom", domain_rstN1, 1'b0);
        soft_rst_req1 = 1'b0;
        tick();    chk("s6_S2_dom", domain_rstN1, 1'b1);
                   chk("s6_S2_done", seq_done1, 1'b1);
                   chk("s6_S2_ack", soft_rst_ack1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
